// File: rtl/stream_crypt_pkg.sv
// Shared types and byte-level cipher helpers for the repeating-key additive stream cipher.
package stream_crypt_pkg;

    typedef logic [7:0] byte_t;

    typedef enum logic {
        S_KEY,
        S_RUN
    } state_t;

    function automatic byte_t dec_byte(input byte_t c, input byte_t k);
        return c - k;
    endfunction

    function automatic byte_t enc_byte(input byte_t p, input byte_t k);
        return p + k;
    endfunction

endpackage

// File: rtl/stream_decrypt.sv
// Byte-serial decryptor: loads a KEY_LEN-byte key, then strips key[i mod KEY_LEN]
// from each byte of MSG_LEN-byte messages through a single valid/ready output register.
module stream_decrypt
    import stream_crypt_pkg::*;
#(
    parameter int MSG_LEN = 9,
    parameter int KEY_LEN = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_valid,
    input  logic [7:0] key_byte,
    output logic       key_ready,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic       out_last,
    input  logic       out_ready,
    output logic       done
);

    localparam int            KW        = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1;
    localparam logic [KW-1:0] KIDX_LAST = KW'(KEY_LEN - 1);
    localparam byte_t         CNT_LAST  = byte_t'(MSG_LEN - 1);

    state_t        state;
    state_t        state_nxt;
    logic [KW-1:0] kidx;
    byte_t         cnt;
    byte_t         key_mem [KEY_LEN];
    byte_t         key_sel;
    logic          boundary;
    logic          key_hs;
    logic          in_hs;
    logic          out_hs;

    // Key reload is only allowed between messages with nothing left in the output register.
    assign boundary = (cnt == 8'd0) && !out_valid;
    assign key_hs   = key_valid && key_ready;
    assign in_hs    = in_valid && in_ready;
    assign out_hs   = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_KEY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_KEY: if (key_hs && kidx == KIDX_LAST) state_nxt = S_RUN;
            S_RUN: if (key_hs && KEY_LEN > 1) state_nxt = S_KEY;
            default: state_nxt = S_KEY;
        endcase
    end

    // A key byte at the boundary wins over a ciphertext byte offered in the same cycle.
    always_comb begin
        key_ready = 1'b0;
        in_ready  = 1'b0;
        case (state)
            S_KEY: key_ready = 1'b1;
            S_RUN: begin
                key_ready = boundary;
                in_ready  = (!out_valid || out_ready) && !(key_valid && boundary);
            end
            default: ;
        endcase
    end

    always_comb begin
        key_sel = key_mem[0];
        for (int i = 1; i < KEY_LEN; i++) begin
            if (kidx == KW'(i)) key_sel = key_mem[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < KEY_LEN; i++) key_mem[i] <= '0;
        end else if (key_hs) begin
            for (int i = 0; i < KEY_LEN; i++) begin
                if ((state == S_KEY && kidx == KW'(i)) || (state == S_RUN && i == 0)) begin
                    key_mem[i] <= key_byte;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kidx <= '0;
            cnt  <= '0;
        end else if (key_hs) begin
            cnt <= '0;
            if (state == S_RUN) begin
                kidx <= (KEY_LEN > 1) ? KW'(1) : '0;
            end else if (kidx == KIDX_LAST) begin
                kidx <= '0;
            end else begin
                kidx <= kidx + 1'b1;
            end
        end else if (in_hs) begin
            // Key phase restarts with every message.
            if (cnt == CNT_LAST) begin
                cnt  <= '0;
                kidx <= '0;
            end else begin
                cnt  <= cnt + 1'b1;
                kidx <= (kidx == KIDX_LAST) ? '0 : kidx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else if (in_hs) begin
            out_valid <= 1'b1;
            out_data  <= dec_byte(in_data, key_sel);
            out_last  <= (cnt == CNT_LAST);
        end else if (out_hs) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done <= 1'b0;
        end else begin
            done <= out_hs && out_last;
        end
    end

endmodule

// File: doc/stream_decrypt.md
Name: stream_decrypt

Overview:
- Byte-serial, clocked counterpart to the combinational encrypt path: removes a repeating-key additive cipher from a stream of MSG_LEN-byte messages.
- Cipher definition: ciphertext[i] = (plain[i] + key[i mod KEY_LEN]) mod 256.
- Sits between the link/byte source carrying encrypted_text and the consumer of decrypted_text.
- Replaces whole-array decrypt with a valid/ready streaming interface, so messages arrive one byte per accepted beat.

Parameters:
- MSG_LEN, 9, bytes per message; range 1..255.
- KEY_LEN, 3, key bytes loaded before decryption; range 1..16.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- key_valid  in  1  key byte offered.
- key_byte  in  8  key byte, index 0 first.
- key_ready  out  1  key byte accepted when key_valid && key_ready.
- in_valid  in  1  ciphertext byte offered.
- in_data  in  8  ciphertext byte.
- in_ready  out  1  ciphertext byte accepted when in_valid && in_ready.
- out_valid  out  1  plaintext byte available.
- out_data  out  8  plaintext byte.
- out_last  out  1  marks message byte MSG_LEN-1; qualified by out_valid.
- out_ready  in  1  consumer accepts when out_valid && out_ready.
- done  out  1  one-cycle pulse when the last byte of a message is accepted downstream.

Behaviour:

Reset:
- State S_KEY; key index, byte counter, key registers = 0.
- out_valid, out_last, done = 0; out_data = 8'h00; in_ready = 0; key_ready = 1.

States:
- S_KEY:
  - key_ready = 1, in_ready = 0.
  - Each key handshake writes key[kidx] and increments kidx.
  - On the handshake with kidx == KEY_LEN-1: go to S_RUN; kidx and byte count reset to 0.
- S_RUN:
  - key_ready = 1 only when byte count == 0 and out_valid == 0 (message boundary, pipeline empty). Otherwise key_ready = 0.
  - A key handshake at the boundary returns to S_KEY. That first byte is stored as key[0] and kidx becomes 1.
  - Key bytes offered mid-message are held off: key_ready = 0, no state change.
  - in_ready = !out_valid || out_ready (single output register, full throughput, no combinational path from in_valid to out_valid).

Datapath:
- On an input handshake: out_data <= in_data - key[kidx] (mod 256, 8-bit wrap).
- out_valid <= 1; out_last <= (byte count == MSG_LEN-1).
- kidx advances modulo KEY_LEN and resets to 0 at each message start.
- Byte count advances modulo MSG_LEN.
- Key phase restarts per message: byte 0 of every message uses key[0].

Latency and flow control:
- Latency is one cycle from input handshake to out_valid.
- out_valid clears on an output handshake with no simultaneous input handshake.
- A simultaneous input and output handshake keeps out_valid = 1 and loads the new byte.
- out_data, out_valid and out_last hold stable while out_valid && !out_ready.

done:
- Registered; pulses high the cycle after the handshake of the byte with out_last = 1.

Boundary conditions:
- MSG_LEN = 1: every byte has out_last = 1.
- KEY_LEN = 1: single-byte key, same byte for every position.
- in_valid while in S_KEY: ignored (in_ready = 0).
- rst_n asserted mid-message: immediate return to reset values. The partial message and the key are discarded; the key must be reloaded.

Decomposition:
- Package stream_crypt_pkg:
  - byte_t (logic [7:0]).
  - state enum {S_KEY, S_RUN}.
  - function dec_byte(c, k) = c - k.
  - function enc_byte(p, k) = p + k, shared with a future stream_encrypt and the bench model.
- No sub-module; a single module of roughly 150–200 lines.

Test Plan:
- Basic message: load key 4B 45 59, stream ciphertext 9B 86 AB 8C 98 9C 93 8E AF, out_ready = 1.
  - Expect "PARASCHIV", one byte per cycle, out_last only on 'V'.
  - Expect done pulse one cycle after 'V' is accepted.
- Wrap-around: KEY_LEN = 1, key C8, input 18.
  - Expect out_data = 50 ('P').
  - Input C8 → 00.
- Backpressure: hold out_ready = 0 for 5 cycles after the first byte.
  - Expect in_ready = 0, out_data stable at 50, no byte loss.
  - Full sequence completes after release.
- Back-to-back messages: send two 9-byte messages with no gap.
  - Expect the second message to restart at key[0] and decrypt to "PARASCHIV" again.
  - Expect two done pulses.
- Key reload:
  - key_valid asserted mid-message → key_ready = 0, stream unaffected.
  - At the boundary, load 01 01 01. Ciphertext 51 42 53 → "PAR".
- Async reset: assert rst_n low at byte 4 between clock edges.
  - Expect out_valid = 0 immediately, key_ready = 1, in_ready = 0.
  - After key reload, a fresh message decrypts correctly.
